// File: rtl/serial_link_pkg.sv
// serial_link_pkg: state encoding and sync pattern shared by both ends of the serial link
package serial_link_pkg;

    // One-hot state encodings; the receiver uses the same values
    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_SYNC = 4'b0010;
    localparam logic [3:0] ST_DATA = 4'b0100;
    localparam logic [3:0] ST_GAP  = 4'b1000;

    typedef enum logic [3:0] {
        IDLE = ST_IDLE,
        SYNC = ST_SYNC,
        DATA = ST_DATA,
        GAP  = ST_GAP
    } state_e;

    localparam int SYNC_W_DEFAULT = 5;
    localparam logic [SYNC_W_DEFAULT-1:0] SYNC_PAT_DEFAULT = 5'b10010;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: sends sync pattern then payload MSB-first, one valid-qualified bit per clock
//   clk, rst     : clock, synchronous active-high reset
//   in_data      : payload word, latched on in_valid && in_ready
//   in_valid     : payload available
//   in_ready     : accepting (IDLE and not in reset)
//   out_bit      : serial bit (registered)
//   out_valid    : out_bit is a frame bit this cycle
//   busy         : frame in progress (state != IDLE)
//   frame_done   : one-cycle pulse in the first cycle after the last frame bit
//   Build option SERIAL_TX_PARITY_EN appends an even-parity bit of the payload after the data bits.
module serial_pattern_tx
    import serial_link_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                SYNC_W     = SYNC_W_DEFAULT,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_W'(SYNC_PAT_DEFAULT),
    parameter int                GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);

`ifdef SERIAL_TX_PARITY_EN
    localparam int DLEN = DATA_W + 1;
`else
    localparam int DLEN = DATA_W;
`endif
    localparam int FW = SYNC_W + DLEN;
    localparam int CW = $clog2(max3(SYNC_W, DLEN, GAP_CYCLES) + 1);
    localparam logic [CW-1:0] S_LAST = CW'(SYNC_W - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DLEN - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [FW-1:0]   fr_q;
    logic            out_bit_q;
    logic            out_valid_q;
    logic            frame_done_q;
    logic [DLEN-1:0] pl;

`ifdef SERIAL_TX_PARITY_EN
    assign pl = {in_data, ^in_data};
`else
    assign pl = in_data;
`endif

    assign in_ready   = (state_q == IDLE) && !rst;
    assign busy       = state_q != IDLE;
    assign out_bit    = out_bit_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

    // fr_q holds the whole frame; the first bit is driven straight out at the
    // handshake so fr_q is loaded pre-shifted and its MSB is always the next bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fr_q         <= '0;
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: if (in_valid && in_ready) begin
                    state_q     <= SYNC;
                    cnt_q       <= '0;
                    fr_q        <= {SYNC_PAT, pl} << 1;
                    out_bit_q   <= SYNC_PAT[SYNC_W-1];
                    out_valid_q <= 1'b1;
                end
                SYNC: begin
                    out_bit_q <= fr_q[FW-1];
                    fr_q      <= fr_q << 1;
                    cnt_q     <= (cnt_q == S_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == S_LAST) state_q <= DATA;
                end
                DATA: if (cnt_q == D_LAST) begin
                    state_q      <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    cnt_q        <= '0;
                    fr_q         <= '0;
                    out_bit_q    <= 1'b0;
                    out_valid_q  <= 1'b0;
                    frame_done_q <= 1'b1;
                end else begin
                    out_bit_q <= fr_q[FW-1];
                    fr_q      <= fr_q << 1;
                    cnt_q     <= cnt_q + 1'b1;
                end
                GAP: if (cnt_q == G_LAST) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
